// File: rtl/riscv_defines.sv
// Shared DIFT definitions: trap classes and the trap-log record layout.
// DIFT_TRAP_LOG_TS_EN adds a 32-bit timestamp field to each log record.
package riscv_defines;

  typedef logic [2:0] dift_trap_t;

  localparam dift_trap_t DIFT_TRAP_TYPE_EXEC = 3'd0;
  localparam dift_trap_t DIFT_TRAP_TYPE_STOR = 3'd1;
  localparam dift_trap_t DIFT_TRAP_TYPE_LOAD = 3'd2;
  localparam dift_trap_t DIFT_TRAP_TYPE_JALR = 3'd3;
  localparam dift_trap_t DIFT_TRAP_TYPE_BRAN = 3'd4;

  localparam int unsigned DIFT_TRAP_NUM_TYPES = 5;

  typedef struct packed {
    dift_trap_t  trap_type;
    logic [31:0] pc;
`ifdef DIFT_TRAP_LOG_TS_EN
    logic [31:0] ts;
`endif
  } dift_trap_log_entry_t;

  localparam int unsigned DIFT_TRAP_LOG_ENTRY_W = $bits(dift_trap_log_entry_t);

endpackage

// File: rtl/dift_trap_log_fifo.sv
// Trap-log record storage: DEPTH entries, extra-MSB pointers, pop-before-push.
module dift_trap_log_fifo
  import riscv_defines::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  logic                             pop,
  input  logic [DIFT_TRAP_LOG_ENTRY_W-1:0] wdata,
  output logic [DIFT_TRAP_LOG_ENTRY_W-1:0] head,
  output logic                             full,
  output logic                             empty,
  output logic                             empty_next
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DIFT_TRAP_LOG_ENTRY_W-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr, wptr_next, rptr_next;
  logic        pop_ok, push_ok;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

  // A same-cycle pop frees a slot, so a push into a full FIFO is still accepted.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  assign wptr_next  = wptr + {{AW{1'b0}}, push_ok};
  assign rptr_next  = rptr + {{AW{1'b0}}, pop_ok};
  assign empty_next = (wptr_next == rptr_next);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= wptr_next;
      rptr <= rptr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= wdata;
  end

  assign head = empty ? '0 : mem[rptr[AW-1:0]];

endmodule

// File: rtl/dift_trap_log.sv
// DIFT trap event log: record FIFO, saturating per-type counters, overflow, irq.
// DIFT_TRAP_LOG_TS_EN enables per-record cycle timestamps on log_ts_o.
module dift_trap_log
  import riscv_defines::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trap_i,
  input  logic [2:0]       trap_type_i,
  input  logic [31:0]      trap_pc_i,
  output logic             log_valid_o,
  input  logic             log_ready_i,
  output logic [2:0]       log_type_o,
  output logic [31:0]      log_pc_o,
  output logic [31:0]      log_ts_o,
  output logic             log_overflow_o,
  input  logic             irq_en_i,
  output logic             irq_o,
  input  logic             clear_i,
  input  logic [2:0]       cnt_sel_i,
  output logic [CNT_W-1:0] cnt_o
);

  dift_trap_log_entry_t wr_entry, head_entry;
  logic [DIFT_TRAP_LOG_ENTRY_W-1:0] head_bits;
  logic                 full, empty, empty_next, drop;
  logic [CNT_W-1:0]     cnt [DIFT_TRAP_NUM_TYPES];
  logic                 overflow, irq;

`ifdef DIFT_TRAP_LOG_TS_EN
  logic [31:0] ts_cnt;

  always_ff @(posedge clk) begin
    if (rst) ts_cnt <= '0;
    else     ts_cnt <= ts_cnt + 32'd1;
  end
`endif

  always_comb begin
    wr_entry           = '0;
    wr_entry.trap_type = trap_type_i;
    wr_entry.pc        = trap_pc_i;
`ifdef DIFT_TRAP_LOG_TS_EN
    wr_entry.ts        = ts_cnt;
`endif
  end

  dift_trap_log_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (trap_i),
    .pop       (log_ready_i),
    .wdata     (wr_entry),
    .head      (head_bits),
    .full      (full),
    .empty     (empty),
    .empty_next(empty_next)
  );

  assign head_entry  = dift_trap_log_entry_t'(head_bits);
  assign log_valid_o = ~empty;
  assign log_type_o  = head_entry.trap_type;
  assign log_pc_o    = head_entry.pc;
`ifdef DIFT_TRAP_LOG_TS_EN
  assign log_ts_o    = head_entry.ts;
`else
  assign log_ts_o    = '0;
`endif

  // Full implies non-empty, so any ready pop makes room for the push.
  assign drop = trap_i & full & ~log_ready_i;

  always_ff @(posedge clk) begin
    if (rst)          overflow <= 1'b0;
    else if (clear_i) overflow <= drop;
    else if (drop)    overflow <= 1'b1;
  end

  // Clear is applied before the increment, so a coincident trap leaves 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DIFT_TRAP_NUM_TYPES; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < DIFT_TRAP_NUM_TYPES; i++) begin
        if (trap_i && (trap_type_i == 3'(i))) begin
          if (clear_i)            cnt[i] <= CNT_W'(1);
          else if (cnt[i] != '1)  cnt[i] <= cnt[i] + CNT_W'(1);
        end else if (clear_i) begin
          cnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    cnt_o = '0;
    for (int unsigned i = 0; i < DIFT_TRAP_NUM_TYPES; i++) begin
      if (cnt_sel_i == 3'(i)) cnt_o = cnt[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) irq <= 1'b0;
    else     irq <= irq_en_i & ~empty_next;
  end

  assign log_overflow_o = overflow;
  assign irq_o          = irq;

endmodule

// File: tb/tb_dift_trap_log.sv
// Self-checking bench for dift_trap_log: queue-based reference model plus directed pins.
module tb_dift_trap_log;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst, trap_i, log_ready_i, irq_en_i, clear_i;
  logic [2:0]       trap_type_i, cnt_sel_i;
  logic [31:0]      trap_pc_i;
  logic             log_valid_o, log_overflow_o, irq_o;
  logic [2:0]       log_type_o;
  logic [31:0]      log_pc_o, log_ts_o;
  logic [CNT_W-1:0] cnt_o;

  dift_trap_log #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .trap_i        (trap_i),
    .trap_type_i   (trap_type_i),
    .trap_pc_i     (trap_pc_i),
    .log_valid_o   (log_valid_o),
    .log_ready_i   (log_ready_i),
    .log_type_o    (log_type_o),
    .log_pc_o      (log_pc_o),
    .log_ts_o      (log_ts_o),
    .log_overflow_o(log_overflow_o),
    .irq_en_i      (irq_en_i),
    .irq_o         (irq_o),
    .clear_i       (clear_i),
    .cnt_sel_i     (cnt_sel_i),
    .cnt_o         (cnt_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a record queue, plain integer counters, sticky flag.
  typedef struct {
    logic [2:0]  t;
    logic [31:0] pc;
    logic [31:0] ts;
  } rec_t;

  rec_t        mq[$];
  int unsigned mcnt[5];
  logic        mov, mirq, chk_on;
  logic [31:0] mts;

  initial chk_on = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      for (int i = 0; i < 5; i++) mcnt[i] = 0;
      mov = 1'b0; mirq = 1'b0; mts = 32'd0; chk_on = 1'b1;
    end else if (chk_on) begin
      rec_t r;
      if (log_ready_i && mq.size() > 0) void'(mq.pop_front());
      if (clear_i) begin
        for (int i = 0; i < 5; i++) mcnt[i] = 0;
        mov = 1'b0;
      end
      if (trap_i) begin
        r.t = trap_type_i; r.pc = trap_pc_i; r.ts = mts;
        if (mq.size() < DEPTH) mq.push_back(r);
        else mov = 1'b1;
        if (trap_type_i < 5 && mcnt[trap_type_i] < CMAX) mcnt[trap_type_i]++;
      end
      mirq = irq_en_i && (mq.size() > 0);
      mts = mts + 32'd1;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      logic        ev;
      logic [2:0]  et;
      logic [31:0] ep, ets, ec;
      ev = mq.size() > 0;
      et = ev ? mq[0].t : 3'd0;
      ep = ev ? mq[0].pc : 32'd0;
`ifdef DIFT_TRAP_LOG_TS_EN
      ets = ev ? mq[0].ts : 32'd0;
`else
      ets = 32'd0;
`endif
      ec = (cnt_sel_i < 5) ? mcnt[cnt_sel_i] : 0;
      check("valid", {31'd0, log_valid_o}, {31'd0, ev});
      check("type", {29'd0, log_type_o}, {29'd0, et});
      check("pc", log_pc_o, ep);
      check("ts", log_ts_o, ets);
      check("overflow", {31'd0, log_overflow_o}, {31'd0, mov});
      check("irq", {31'd0, irq_o}, {31'd0, mirq});
      check("cnt", {{(32-CNT_W){1'b0}}, cnt_o}, ec);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    trap_i = 1'b0; log_ready_i = 1'b0; clear_i = 1'b0;
    trap_type_i = 3'd0; trap_pc_i = 32'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  logic [31:0] drain_pc[4];
  logic [31:0] t0;

  initial begin
    idle_inputs();
    irq_en_i = 1'b1; cnt_sel_i = 3'd0;
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    check("rst_valid", {31'd0, log_valid_o}, 32'd0);
    check("rst_irq", {31'd0, irq_o}, 32'd0);
    check("rst_cnt", {16'd0, cnt_o}, 32'd0);

    // Single trap: visible next cycle, irq raised, counter 2 = 1
    cnt_sel_i = 3'd2;
    trap_i = 1'b1; trap_type_i = 3'd2; trap_pc_i = 32'h0000_1A40;
    cyc();
    idle_inputs();
    check("t1_valid", {31'd0, log_valid_o}, 32'd1);
    check("t1_type", {29'd0, log_type_o}, 32'd2);
    check("t1_pc", log_pc_o, 32'h1A40);
    check("t1_irq", {31'd0, irq_o}, 32'd1);
    check("t1_cnt", {16'd0, cnt_o}, 32'd1);

    do_reset();
    check("midrst_valid", {31'd0, log_valid_o}, 32'd0);

    // Five traps into a 4-deep log
    for (int i = 0; i < 5; i++) begin
      trap_i = 1'b1; trap_type_i = 3'(i); trap_pc_i = 32'h100 + 32'(i);
      cyc();
    end
    idle_inputs();
    check("of_flag", {31'd0, log_overflow_o}, 32'd1);
    check("of_head", log_pc_o, 32'h100);
    for (int i = 0; i < 5; i++) begin
      cnt_sel_i = 3'(i);
      #1;
      check("of_cnt", {16'd0, cnt_o}, 32'd1);
    end

    clear_i = 1'b1;
    cyc();
    clear_i = 1'b0;
    check("clr_ov", {31'd0, log_overflow_o}, 32'd0);
    check("clr_keep", {31'd0, log_valid_o}, 32'd1);
    check("clr_cnt", {16'd0, cnt_o}, 32'd0);

    // Full + simultaneous pop and push
    trap_i = 1'b1; trap_type_i = 3'd3; trap_pc_i = 32'h200; log_ready_i = 1'b1;
    cyc();
    idle_inputs();
    check("fp_ov", {31'd0, log_overflow_o}, 32'd0);
    check("fp_head", log_pc_o, 32'h101);

    drain_pc[0] = 32'h101; drain_pc[1] = 32'h102;
    drain_pc[2] = 32'h103; drain_pc[3] = 32'h200;
    log_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("drain_pc", log_pc_o, drain_pc[k]);
      cyc();
    end
    check("drain_valid", {31'd0, log_valid_o}, 32'd0);
    check("drain_irq", {31'd0, irq_o}, 32'd0);
    cyc(); cyc(); cyc();
    log_ready_i = 1'b0;
    trap_i = 1'b1; trap_type_i = 3'd5; trap_pc_i = 32'h300;
    cnt_sel_i = 3'd5;
    cyc();
    idle_inputs();
    check("post_pc", log_pc_o, 32'h300);
    check("post_type", {29'd0, log_type_o}, 32'd5);
    check("sel5_cnt", {16'd0, cnt_o}, 32'd0);
    log_ready_i = 1'b1;
    cyc();
    log_ready_i = 1'b0;

    // Saturation then clear with coincident trap
    cnt_sel_i = 3'd1;
    trap_i = 1'b1; trap_type_i = 3'd1; trap_pc_i = 32'h400;
    repeat (CMAX) cyc();
    check("sat_cnt", {16'd0, cnt_o}, 32'hFFFF);
    cyc();
    check("sat_hold", {16'd0, cnt_o}, 32'hFFFF);
    clear_i = 1'b1; log_ready_i = 1'b1;
    cyc();
    idle_inputs();
    check("clrtrap_cnt", {16'd0, cnt_o}, 32'd1);
    check("clrtrap_ov", {31'd0, log_overflow_o}, 32'd0);

    // Timestamp spacing
    do_reset();
    trap_i = 1'b1; trap_pc_i = 32'h10;
    cyc();
    idle_inputs();
    repeat (9) cyc();
    trap_i = 1'b1; trap_pc_i = 32'h20;
    cyc();
    idle_inputs();
`ifdef DIFT_TRAP_LOG_TS_EN
    t0 = log_ts_o;
    log_ready_i = 1'b1;
    cyc();
    log_ready_i = 1'b0;
    check("ts_diff", log_ts_o - t0, 32'd10);
`else
    check("ts_zero", log_ts_o, 32'd0);
    log_ready_i = 1'b1;
    cyc();
    log_ready_i = 1'b0;
    check("ts_zero2", log_ts_o, 32'd0);
`endif

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      rst         = ($urandom_range(0, 199) == 0);
      trap_i      = $urandom_range(0, 1);
      trap_type_i = 3'($urandom_range(0, 7));
      trap_pc_i   = $urandom;
      log_ready_i = ($urandom_range(0, 2) == 0);
      clear_i     = ($urandom_range(0, 19) == 0);
      irq_en_i    = ($urandom_range(0, 9) != 0);
      cnt_sel_i   = 3'($urandom_range(0, 7));
      cyc();
    end
    rst = 1'b0;
    idle_inputs();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dift_trap_log.md
Name: dift_trap_log

Overview:
- Sits directly downstream of the DIFT tag check unit and consumes its registered trap tick (`trap`, `trap_type`).
- Captures each DIFT trap event with the faulting PC into a small FIFO that software drains through the CSR path.
- Keeps saturating per-type event counters and a sticky overflow flag.
- Drives a level interrupt-pending signal toward the controller while unread records exist.

Parameters:
- DEPTH, 4, number of log entries; power of two, >= 2.
- CNT_W, 16, width of each per-type saturating event counter.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- trap_i  in  1  single-cycle trap tick from tag check unit
- trap_type_i  in  3 (dift_trap_t)  trap class: EXEC=0, STOR=1, LOAD=2, JALR=3, BRAN=4
- trap_pc_i  in  32  PC of the instruction that raised the trap, aligned with trap_i
- log_valid_o  out  1  FIFO non-empty; head record valid
- log_ready_i  in  1  pop request from CSR read of the head record
- log_type_o  out  3  head record trap type
- log_pc_o  out  32  head record PC
- log_ts_o  out  32  head record timestamp (see Optional Feature)
- log_overflow_o  out  1  sticky: at least one event was dropped
- irq_en_i  in  1  interrupt enable (CSR bit)
- irq_o  out  1  interrupt pending
- clear_i  in  1  clears counters and overflow flag
- cnt_sel_i  in  3  selects the counter shown on cnt_o
- cnt_o  out  CNT_W  counter value for trap type cnt_sel_i

Behaviour:
- Reset (rst=1 at posedge): FIFO empty, read/write pointers 0, counters 0, overflow 0.
  - Reset values: log_valid_o=0, log_type_o=0, log_pc_o=0, log_ts_o=0, irq_o=0, cnt_o=0.
  - Reset mid-operation discards all entries immediately.
- Push: on a cycle with trap_i=1, {trap_type_i, trap_pc_i[, ts]} is written at the write pointer.
  - The record is visible on the log outputs from the next cycle; push-to-log_valid_o latency is 1.
- Pop: a handshake occurs when log_valid_o & log_ready_i. The read pointer advances and the next head appears the following cycle.
  - log_ready_i is ignored while the FIFO is empty.
- Head outputs are registered/muxed from storage. When empty they hold 0.
- Full FIFO, trap_i=1, no pop: the event is dropped, log_overflow_o is set, and FIFO contents are unchanged.
- Full FIFO, trap_i=1, pop in the same cycle: the pop takes effect first, so the push is accepted, the count stays DEPTH, and there is no overflow.
- Empty FIFO, trap_i=1, log_ready_i=1: no pop; the push is accepted.
- Pointers are log2(DEPTH)+1 bits with natural wrap-around. Full = MSBs differ and the low bits are equal.
- Counters: on trap_i with trap_type_i in 0..4, counter[trap_type_i] increments and saturates at 2^CNT_W-1.
  - Counters increment even when the event is dropped.
  - For trap_type_i in 5..7 the event is still logged but no counter changes.
- cnt_o is a combinational mux of counter[cnt_sel_i]; it outputs 0 for cnt_sel_i >= 5.
- clear_i: counters and overflow go to 0 at the next edge. FIFO contents are unaffected.
  - clear_i with a simultaneous trap_i: clear applies first, then the increment, so the selected counter = 1.
  - clear_i with a simultaneous dropped event: overflow reads 1 after that edge.
- irq_o is registered: irq_o(next) = irq_en_i & (FIFO non-empty after this cycle's push/pop).
  - Deasserts the cycle after the last entry is popped.
- A trap_i held high for multiple cycles logs one entry per cycle. Upstream guarantees a tick, so no edge detection is done here.

Optional Feature:
- Macro: DIFT_TRAP_LOG_TS_EN.
- Defined: a 32-bit free-running cycle counter (reset 0, wraps at 2^32) is stored with each entry and presented on log_ts_o. The stored value is the count in the push cycle.
- Undefined: no timestamp storage or counter; log_ts_o is tied to 0.

Decomposition:
- The riscv_defines package holds:
  - dift_trap_t and the DIFT_TRAP_TYPE_* constants, which are existing types.
  - A new struct dift_trap_log_entry_t {type, pc[, ts]}.
  - A new constant DIFT_TRAP_NUM_TYPES=5.
- One sub-module, dift_trap_log_fifo: parametric DEPTH storage with pointers and full/empty. It has push/pop/full/empty ports and a pop-before-push rule.
- Counters, overflow flag, irq and timestamp stay in the top level.

Test Plan:
- After reset, one pulse trap_i with type=2 and pc=0x0000_1A40 -> next cycle log_valid_o=1, log_type_o=2, log_pc_o=0x1A40, irq_o=1 (irq_en_i=1); cnt_sel_i=2 gives cnt_o=1.
- 5 consecutive traps with types 0,1,2,3,4 and DEPTH=4, no pops -> four entries hold types 0..3, log_overflow_o=1, and counters 0..4 each read 1.
- FIFO full, then trap_i with pc=0x200 and log_ready_i=1 in the same cycle -> no overflow, the oldest entry is removed, and the tail entry has pc=0x200.
- Drain all entries with log_ready_i held high -> log_valid_o=0 and irq_o=0 one cycle after the last pop; extra pops leave the pointers unchanged.
- Force counter 1 to 0xFFFF, then trap type 1 -> stays at 0xFFFF. Then clear_i together with a type-1 trap -> cnt_o=1 and overflow=0.
- With DIFT_TRAP_LOG_TS_EN defined: traps 10 cycles apart after reset -> log_ts_o difference = 10. With the macro undefined -> log_ts_o always 0.
